// File: rtl/spawn_stream_arbiter_pkg.sv
// Shared helpers for the spawn notification stream arbiter.
// Only width helpers live here; protocol constants stay elsewhere.
package spawn_stream_arbiter_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spawn_stream_arbiter_rr_picker.sv
// Rotated first-one search: lowest requester strictly after i_last,
// wrapping modulo NUM_IN.
module spawn_stream_arbiter_rr_picker
  import spawn_stream_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int ID_W   = id_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [ID_W-1:0]   i_last,
  output logic              o_any,
  output logic [ID_W-1:0]   o_idx
);

  logic [ID_W-1:0]   w_start;
  logic [ID_W-1:0]   w_off;
  logic [NUM_IN-1:0] w_rot;
  logic [ID_W:0]     w_sum;

  assign o_any   = |i_req;
  assign w_start = (i_last >= ID_W'(NUM_IN - 1)) ? '0
                 : i_last + ID_W'(1);

  // Bit j of w_rot is request (w_start + j) mod NUM_IN.
  assign w_rot = NUM_IN'({i_req, i_req} >> w_start);

  always_comb begin
    w_off = '0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = ID_W'(j);
    end
  end

  assign w_sum = {1'b0, w_start} + {1'b0, w_off};
  assign o_idx = (w_sum >= (ID_W+1)'(NUM_IN))
               ? ID_W'(w_sum - (ID_W+1)'(NUM_IN))
               : w_sum[ID_W-1:0];

endmodule

// File: rtl/spawn_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN AXI-Stream sources
// onto the single taskwait/notification stream.
module spawn_stream_arbiter
  import spawn_stream_arbiter_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int DATA_W = 64,
  localparam int ID_W   = id_width(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] inStream_TDATA,
  input  logic [NUM_IN-1:0]        inStream_TVALID,
  input  logic [NUM_IN-1:0]        inStream_TLAST,
  output logic [NUM_IN-1:0]        inStream_TREADY,
  output logic [DATA_W-1:0]        outStream_TDATA,
  output logic                     outStream_TVALID,
  output logic                     outStream_TLAST,
  output logic [ID_W-1:0]          outStream_TID,
  input  logic                     outStream_TREADY,
  output logic                     busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_grant_nxt;
  logic [ID_W-1:0] w_last_nxt;
  logic [ID_W-1:0] w_pick;
  logic            w_any;
  logic            w_valid;
  logic            w_tlast;
  logic [DATA_W-1:0] w_data [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign w_data[i] = inStream_TDATA[i*DATA_W +: DATA_W];
  end

  spawn_stream_arbiter_rr_picker #(
    .NUM_IN (NUM_IN),
    .ID_W   (ID_W)
  ) u_picker (
    .i_req  (inStream_TVALID),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_pick)
  );

  assign w_valid = inStream_TVALID[r_grant];
  assign w_tlast = inStream_TLAST[r_grant];

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_nxt       = r_last;
    outStream_TDATA  = '0;
    outStream_TVALID = 1'b0;
    outStream_TLAST  = 1'b0;
    outStream_TID    = r_last;
    inStream_TREADY  = '0;
    busy             = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick;
        end
      end
      LOCKED: begin
        busy             = 1'b1;
        outStream_TDATA  = w_data[r_grant];
        outStream_TVALID = w_valid;
        outStream_TLAST  = w_tlast;
        outStream_TID    = r_grant;
        inStream_TREADY[r_grant] = outStream_TREADY;
        // Lock holds through source stalls until the last beat moves.
        if (w_valid && outStream_TREADY && w_tlast) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= ID_W'(NUM_IN - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_spawn_stream_arbiter.sv
// Directed scoreboard bench for spawn_stream_arbiter.
module tb_spawn_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          gap;
  } beat_t;

  typedef struct {
    logic [1:0]  tid;
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_rdy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic [1:0]    out_tid;
  logic          out_rdy = 1'b1;
  logic          busy;

  beat_t srcq [N][$];
  exp_t  exp_q[$];
  exp_t  e;
  int    acc_q[$];
  int    cyc  = 0;
  int    nvec = 0;
  int    nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spawn_stream_arbiter #(
    .NUM_IN (N),
    .DATA_W (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .inStream_TDATA   (in_data),
    .inStream_TVALID  (in_valid),
    .inStream_TLAST   (in_last),
    .inStream_TREADY  (in_rdy),
    .outStream_TDATA  (out_data),
    .outStream_TVALID (out_valid),
    .outStream_TLAST  (out_last),
    .outStream_TID    (out_tid),
    .outStream_TREADY (out_rdy),
    .busy             (busy)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : src
    logic          v = 1'b0;
    logic          l = 1'b0;
    logic [DW-1:0] d = '0;
    logic          hs;
    beat_t         b;
    assign in_valid[g]          = v;
    assign in_last[g]           = l;
    assign in_data[g*DW +: DW]  = d;
    initial forever begin
      if (srcq[g].size() == 0) begin
        v = 1'b0; l = 1'b0; d = '0;
        @(posedge clk); #1;
      end else begin
        b = srcq[g][0];
        if (b.gap > 0) begin
          v = 1'b0; l = 1'b0; d = '0;
          repeat (b.gap) begin @(posedge clk); #1; end
        end
        v = 1'b1; l = b.last; d = b.data;
        do begin
          @(negedge clk); hs = in_rdy[g];
          @(posedge clk); #1;
        end while (!hs);
        srcq[g].delete(0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_rdy) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected beat", {out_tid, out_data, out_last}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {out_tid, out_data, out_last},
            {e.tid, e.data, e.last});
      end
    end
  end

  task automatic push_beat(input int s, input logic [63:0] dat,
                           input logic lst, input int gap);
    beat_t b;
    b.data = dat; b.last = lst; b.gap = gap;
    srcq[s].push_back(b);
  endtask

  task automatic exp_beat(input logic [1:0] t, input logic [63:0] dat,
                          input logic lst);
    exp_t x;
    x.tid = t; x.data = dat; x.last = lst;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk); n++;
    end
    chk("drain", 128'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst valid/last/busy", {out_valid, out_last, busy}, 0);
    chk("rst data", out_data, 0);
    chk("rst tid", out_tid, 3);
    chk("rst tready", in_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single 2-beat packet from source 2
    @(negedge clk);
    c0 = cyc; acc_q.delete();
    push_beat(2, 64'hA, 1'b0, 0);
    push_beat(2, 64'hB, 1'b1, 0);
    exp_beat(2, 64'hA, 1'b0);
    exp_beat(2, 64'hB, 1'b1);
    wait_drain(20);
    chk("t1 first beat latency", 128'(acc_q[0] - c0), 2);
    chk("t1 beat spacing", 128'(acc_q[1] - acc_q[0]), 1);
    chk("t1 idle busy/tid", {busy, out_tid}, {1'b0, 2'd2});

    // all sources contend, round robin from source 0
    do_reset();
    @(negedge clk);
    acc_q.delete();
    push_beat(0, 64'h100, 1'b0, 0); push_beat(0, 64'h101, 1'b1, 0);
    push_beat(0, 64'h110, 1'b0, 0); push_beat(0, 64'h111, 1'b1, 0);
    push_beat(1, 64'h200, 1'b0, 0); push_beat(1, 64'h201, 1'b1, 0);
    push_beat(2, 64'h300, 1'b0, 0); push_beat(2, 64'h301, 1'b1, 0);
    push_beat(3, 64'h400, 1'b0, 0); push_beat(3, 64'h401, 1'b1, 0);
    exp_beat(0, 64'h100, 1'b0); exp_beat(0, 64'h101, 1'b1);
    exp_beat(1, 64'h200, 1'b0); exp_beat(1, 64'h201, 1'b1);
    exp_beat(2, 64'h300, 1'b0); exp_beat(2, 64'h301, 1'b1);
    exp_beat(3, 64'h400, 1'b0); exp_beat(3, 64'h401, 1'b1);
    exp_beat(0, 64'h110, 1'b0); exp_beat(0, 64'h111, 1'b1);
    wait_drain(60);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t2 pkt%0d start", k),
          128'(acc_q[2*k] - acc_q[0]), 128'(3*k));
    end

    // source 1 stalls mid-packet, source 3 waits
    @(negedge clk);
    c0 = cyc; acc_q.delete();
    push_beat(1, 64'h51, 1'b0, 0); push_beat(1, 64'h52, 1'b1, 5);
    push_beat(3, 64'h53, 1'b0, 0); push_beat(3, 64'h54, 1'b1, 0);
    exp_beat(1, 64'h51, 1'b0); exp_beat(1, 64'h52, 1'b1);
    exp_beat(3, 64'h53, 1'b0); exp_beat(3, 64'h54, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3 stall %0d", i),
          {busy, out_valid, in_rdy[3], in_rdy[1]}, 4'b1001);
      @(negedge clk);
    end
    wait_drain(30);
    chk("t3 resume gap", 128'(acc_q[1] - acc_q[0]), 6);

    // downstream backpressure mid-packet on source 2
    @(negedge clk);
    acc_q.delete();
    push_beat(2, 64'h44, 1'b0, 0); push_beat(2, 64'h55, 1'b1, 0);
    exp_beat(2, 64'h44, 1'b0); exp_beat(2, 64'h55, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4 hold %0d", i),
          {out_valid, out_last, out_data}, {1'b1, 1'b1, 64'h55});
      chk($sformatf("t4 tready %0d", i), in_rdy, 4'b0000);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("t4 tready resume", in_rdy, 4'b0100);
    wait_drain(20);

    // single-beat packets alternate between sources 0 and 1
    @(negedge clk);
    acc_q.delete();
    push_beat(0, 64'h61, 1'b1, 0); push_beat(0, 64'h63, 1'b1, 0);
    push_beat(1, 64'h62, 1'b1, 0); push_beat(1, 64'h64, 1'b1, 0);
    exp_beat(0, 64'h61, 1'b1); exp_beat(1, 64'h62, 1'b1);
    exp_beat(0, 64'h63, 1'b1); exp_beat(1, 64'h64, 1'b1);
    wait_drain(30);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("t5 pkt%0d start", k),
          128'(acc_q[k] - acc_q[0]), 128'(2*k));
    end

    // reset in the middle of a source 3 packet
    @(negedge clk);
    acc_q.delete();
    push_beat(3, 64'h77, 1'b0, 0); push_beat(3, 64'h88, 1'b1, 0);
    exp_beat(3, 64'h77, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    chk("t6 locked", {busy, out_valid, out_data}, {1'b1, 1'b1, 64'h88});
    rst = 1'b1;
    #1;
    chk("t6 rst ctrl", {out_valid, out_last, busy, out_tid, in_rdy},
        {1'b0, 1'b0, 1'b0, 2'd3, 4'b0000});
    chk("t6 rst data", out_data, 0);
    push_beat(0, 64'h99, 1'b0, 0); push_beat(0, 64'h9A, 1'b1, 0);
    exp_beat(0, 64'h99, 1'b0); exp_beat(0, 64'h9A, 1'b1);
    exp_beat(3, 64'h88, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spawn_stream_arbiter.md
# spawn_stream_arbiter

Packet-atomic round-robin arbiter that merges NUM_IN TLAST-framed 64-bit AXI-Stream sources into one output stream toward the taskwait/notification path. Each source is a Spawn-In–style producer emitting two-beat notification packets (TYPE header, then task id with TLAST). The block shares the single downstream stream fairly and never interleaves beats of different packets.

## Interface
- NUM_IN, 4, number of requesting streams (1..16)
- DATA_W, 64, stream data width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- inStream_TDATA  in  NUM_IN*DATA_W  source data, source i at [i*DATA_W +: DATA_W]
- inStream_TVALID  in  NUM_IN  per-source valid
- inStream_TLAST  in  NUM_IN  per-source end of packet
- inStream_TREADY  out  NUM_IN  per-source ready; at most one bit high
- outStream_TDATA  out  DATA_W  merged data
- outStream_TVALID  out  1  merged valid
- outStream_TLAST  out  1  merged end of packet
- outStream_TID  out  max(1,$clog2(NUM_IN))  index of the source owning the current packet
- outStream_TREADY  in  1  downstream ready
- busy  out  1  high while a packet is locked

## Operation
- States: IDLE, LOCKED.
- IDLE: if any inStream_TVALID is high, choose the first valid source scanning upward from last_grant+1 (mod NUM_IN), register grant and last_grant, go to LOCKED. If none is valid, stay.
- LOCKED: pure pass-through of source grant: outStream_TDATA/TVALID/TLAST = source grant; inStream_TREADY[grant] = outStream_TREADY; other TREADY bits 0; outStream_TID = grant.
- Beat accepted = outStream_TVALID & outStream_TREADY. A beat accepted with TLAST moves to IDLE.
- A source deasserting TVALID mid-packet keeps the lock; the block waits indefinitely (no timeout).
- In IDLE: outStream_TVALID = 0, all inStream_TREADY = 0, outStream_TDATA = 0, TLAST = 0, TID = last_grant.
- Single-beat packets (TLAST on first beat) are legal.
- NUM_IN = 1 is legal: same state machine, grant always 0.

## Timing
- Reset values: state IDLE, grant 0, last_grant NUM_IN-1 (so source 0 wins first), busy 0, outStream_TVALID 0, TLAST 0, TDATA 0, TID NUM_IN-1, all inStream_TREADY 0.
- Reset asserted mid-packet: state returns to IDLE immediately (asynchronous); the partial packet is abandoned downstream; the source must restart.
- Arbitration latency: 1 cycle; a source valid in cycle N may transfer its first beat in cycle N+1.
- Throughput: 1 beat/cycle inside a packet; one IDLE bubble cycle between packets (2-beat packet = 3 cycles minimum).
- Sources follow AXI-Stream rules: TDATA/TLAST stable while TVALID & !TREADY. The block adds no registering on the data path; TREADY→TREADY and TVALID→TVALID are combinational in LOCKED.
- The grant decision uses TVALID sampled in IDLE only; a source raising TVALID while another is LOCKED waits for the next IDLE.
- Fairness: with all sources continuously valid, grant order is 0,1,…,NUM_IN-1,0,…; no source waits more than NUM_IN-1 packets.

## Structure
- State enum local to the module; no new constants in the shared OmpSsManager package (TYPE_B and the entry offsets stay there and are not used here).
- One combinational sub-module is natural: rr_picker (inputs req[NUM_IN], last[ID_W]; outputs any, idx[ID_W]) implementing the rotated first-one search.

## Test plan
- Reset, then source 2 sends 2-beat packet {0xA, 0xB+TLAST}, TREADY=1 -> TID=2, beats at cycles 1 and 2 after valid, busy falls after TLAST.
- Sources 0-3 all valid with 2-beat packets continuously, TREADY=1 -> grant order 0,1,2,3,0; no interleaving; 3 cycles per packet.
- Source 1 locked, drops TVALID for 5 cycles between beats while source 3 valid -> output stalls, source 3 TREADY stays 0, source 1 resumes and finishes.
- Downstream TREADY=0 for 4 cycles mid-packet -> TDATA/TLAST held, only grant TREADY follows outStream_TREADY.
- Single-beat packets (TLAST on first beat) from sources 0 and 1 -> each completes in 2 cycles, alternating.
- Assert rst after first beat of a packet from source 3 -> outputs go to reset values same cycle; after release, source 0 wins if valid.
